// File: rtl/leaf_port_arbiter.sv
// Round-robin burst arbiter that shares one leaf_interface user input slot
// among NUM_REQ vld/ack producer streams, with a one-entry registered output.
module leaf_port_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int PAYLOAD_BITS = 32,
    parameter int BURST_LEN    = 16,
    parameter int REQ_BITS     = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] din_user2arb,
    input  logic [NUM_REQ-1:0]              vld_user2arb,
    output logic [NUM_REQ-1:0]              ack_arb2user,
    output logic [PAYLOAD_BITS-1:0]         dout_arb2interface,
    output logic                            vld_arb2interface,
    input  logic                            ack_interface2arb,
    output logic                            grant_vld,
    output logic [REQ_BITS-1:0]             grant_id
);
    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [REQ_BITS-1:0]     grant_q, grant_d;
    logic [REQ_BITS-1:0]     last_q, last_d;
    logic                    o_vld_q, o_vld_d;
    logic [PAYLOAD_BITS-1:0] o_data_q, o_data_d;

    logic                    can_load;
    logic                    accept;
    logic                    gnt_vld;
    logic [PAYLOAD_BITS-1:0] gnt_data;
    logic                    hi_found, lo_found, sel_found;
    logic [REQ_BITS-1:0]     hi_id, lo_id, sel_id;

    assign can_load           = !o_vld_q || ack_interface2arb;
    assign accept             = (state_q == S_BURST) && gnt_vld && can_load;
    assign vld_arb2interface  = o_vld_q;
    assign dout_arb2interface = o_data_q;
    assign grant_vld          = (state_q == S_BURST);
    assign grant_id           = grant_q;

    always_comb begin
        gnt_vld      = 1'b0;
        gnt_data     = '0;
        ack_arb2user = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == REQ_BITS'(i)) begin
                gnt_vld         = vld_user2arb[i];
                gnt_data        = din_user2arb[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                ack_arb2user[i] = (state_q == S_BURST) && can_load;
            end
        end
    end

    // Rotating priority: the first requester above last_q wins, else wrap to the lowest.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!hi_found && vld_user2arb[i] && (REQ_BITS'(i) > last_q)) begin
                hi_found = 1'b1;
                hi_id    = REQ_BITS'(i);
            end
            if (!lo_found && vld_user2arb[i] && (REQ_BITS'(i) <= last_q)) begin
                lo_found = 1'b1;
                lo_id    = REQ_BITS'(i);
            end
        end
        sel_found = hi_found || lo_found;
        sel_id    = hi_found ? hi_id : lo_id;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        last_d   = last_q;
        o_vld_d  = o_vld_q;
        o_data_d = o_data_q;

        if (accept) begin
            o_vld_d  = 1'b1;
            o_data_d = gnt_data;
        end else if (ack_interface2arb) begin
            o_vld_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && sel_found) begin
                    grant_d = sel_id;
                    cnt_d   = '0;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (!gnt_vld) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end else if (can_load) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        last_d  = grant_q;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            grant_q  <= '0;
            last_q   <= REQ_BITS'(NUM_REQ - 1);
            o_vld_q  <= 1'b0;
            o_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            o_vld_q  <= o_vld_d;
            o_data_q <= o_data_d;
        end
    end

endmodule

// File: tb/tb_leaf_port_arbiter.sv
// Randomized scoreboard bench for leaf_port_arbiter: producer queues feed the DUT,
// a transaction-level round-robin model predicts the output word order.
module tb_leaf_port_arbiter;
    localparam int NR = 2;
    localparam int PB = 32;
    localparam int BL = 16;
    localparam int RB = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [NR*PB-1:0] din;
    logic [NR-1:0]    vld;
    logic [NR-1:0]    ack_u;
    logic [PB-1:0]    dout;
    logic             vld_o;
    logic             ack_if;
    logic             grant_vld;
    logic [RB-1:0]    grant_id;

    leaf_port_arbiter #(
        .NUM_REQ      (NR),
        .PAYLOAD_BITS (PB),
        .BURST_LEN    (BL),
        .REQ_BITS     (RB)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .din_user2arb       (din),
        .vld_user2arb       (vld),
        .ack_arb2user       (ack_u),
        .dout_arb2interface (dout),
        .vld_arb2interface  (vld_o),
        .ack_interface2arb  (ack_if),
        .grant_vld          (grant_vld),
        .grant_id           (grant_id)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] pq [NR][$];
    logic [31:0] exp_q [$];
    int          mlast;
    logic [NR-1:0] prod_fire = '0;
    logic        bp_mode = 1'b0;
    logic        drv_hold = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Words are granted in bursts of up to BL, visiting non-empty producers in
    // rotating order starting after the previously served one.
    task automatic model_push(input int n0, input logic [31:0] b0,
                              input int n1, input logic [31:0] b1);
        int          rem [NR];
        int          nxt [NR];
        logic [31:0] base [NR];
        int          c;
        int          take;
        logic        found;
        rem[0] = n0; rem[1] = n1;
        base[0] = b0; base[1] = b1;
        for (int i = 0; i < NR; i++) begin
            nxt[i] = 0;
            for (int n = 0; n < rem[i]; n++) pq[i].push_back(base[i] + 32'(n));
        end
        while (rem[0] + rem[1] > 0) begin
            found = 1'b0;
            c = mlast;
            for (int k = 1; k <= NR; k++) begin
                if (!found && rem[(mlast + k) % NR] > 0) begin
                    found = 1'b1;
                    c = (mlast + k) % NR;
                end
            end
            take = (rem[c] < BL) ? rem[c] : BL;
            for (int t = 0; t < take; t++) exp_q.push_back(base[c] + 32'(nxt[c] + t));
            nxt[c] += take;
            rem[c] -= take;
            mlast = c;
        end
    endtask

    // Producer driver: present queue heads, then note which words the DUT accepts.
    always @(negedge clk) begin
        for (int i = 0; i < NR; i++)
            if (prod_fire[i] && pq[i].size() > 0) void'(pq[i].pop_front());
        prod_fire = '0;
        for (int i = 0; i < NR; i++) begin
            if (!drv_hold && pq[i].size() > 0) begin
                vld[i] = 1'b1;
                din[i*PB +: PB] = pq[i][0];
            end else begin
                vld[i] = 1'b0;
            end
        end
        ack_if = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (vld[i] && ack_u[i]) begin
                prod_fire[i] = 1'b1;
                chk("grant_id_on_accept", 32'(grant_id), 32'(i));
            end
        end
    end

    // Output monitor: pops the scoreboard on each interface handshake.
    always @(negedge clk) begin
        #2;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_vld", 32'(vld_o), 32'd1);
                chk("stall_hold_data", dout, prev_data);
            end
            if (vld_o && ack_if) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none at %0t", dout, $time);
                end else begin
                    chk("out_data", dout, exp_q.pop_front());
                end
            end
            prev_stall = vld_o && !ack_if;
            prev_data  = dout;
        end
    end

    task automatic tick();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((pq[0].size() > 0 || pq[1].size() > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        mlast = NR - 1;
    endtask

    initial begin
        int hi;
        int gap_at;
        int n;
        int exp_first;
        reset  = 1'b1;
        enable = 1'b1;
        ack_if = 1'b1;
        vld    = '0;
        din    = '0;
        mlast  = NR - 1;
        repeat (2) tick();
        chk("rst_vld_out", 32'(vld_o), 32'd0);
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_ack", 32'(ack_u), 32'd0);
        reset = 1'b0;

        // single requester, 20 words: latency, burst length, one bubble
        model_push(20, 32'h100, 0, 32'h0);
        tick();
        chk("arb_cycle_grant_vld", 32'(grant_vld), 32'd0);
        tick();
        chk("lat_vld_out_n1", 32'(vld_o), 32'd0);
        chk("lat_grant_vld_n1", 32'(grant_vld), 32'd1);
        chk("lat_grant_id_n1", 32'(grant_id), 32'd0);
        tick();
        hi = 0;
        gap_at = -1;
        for (int s = 0; s < 21; s++) begin
            if (vld_o) hi++;
            else if (gap_at < 0) gap_at = s;
            if (s < 20) tick();
        end
        chk("single_req_words", 32'(hi), 32'd20);
        chk("single_req_bubble_pos", 32'(gap_at), 32'd16);
        wait_done(200);

        // both requesters continuously valid
        do_reset();
        model_push(48, 32'hA000, 48, 32'hB000);
        wait_done(400);

        // random interface backpressure
        bp_mode = 1'b1;
        model_push(0, 32'h0, 40, 32'hC000);
        wait_done(1000);
        bp_mode = 1'b0;

        // short burst from req1 releases early, then req0
        model_push(1, 32'hD000, 0, 32'h0);
        wait_done(100);
        model_push(5, 32'hE000, 3, 32'hE100);
        wait_done(200);

        // enable low blocks new grants
        enable = 1'b0;
        exp_first = (mlast + 1) % NR;
        model_push(4, 32'hF000, 4, 32'hF100);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("disabled_ack", 32'(ack_u), 32'd0);
            chk("disabled_grant_vld", 32'(grant_vld), 32'd0);
        end
        enable = 1'b1;
        n = 0;
        while (!grant_vld && n < 10) begin
            tick();
            n++;
        end
        chk("enable_first_grant", 32'(grant_id), 32'(exp_first));
        wait_done(200);

        // reset mid-burst with the output register full
        model_push(0, 32'h0, 10, 32'h5100);
        n = 0;
        while (!vld_o && n < 20) begin
            tick();
            n++;
        end
        chk("pre_reset_vld_out", 32'(vld_o), 32'd1);
        chk("pre_reset_grant_id", 32'(grant_id), 32'd1);
        reset = 1'b1;
        drv_hold = 1'b1;
        prod_fire = '0;
        for (int i = 0; i < NR; i++) pq[i].delete();
        exp_q.delete();
        tick();
        reset = 1'b0;
        chk("post_reset_vld_out", 32'(vld_o), 32'd0);
        chk("post_reset_grant_vld", 32'(grant_vld), 32'd0);
        chk("post_reset_ack", 32'(ack_u), 32'd0);
        chk("post_reset_grant_id", 32'(grant_id), 32'd0);
        drv_hold = 1'b0;
        mlast = NR - 1;
        model_push(2, 32'h6000, 2, 32'h6100);
        n = 0;
        while (!grant_vld && n < 10) begin
            tick();
            n++;
        end
        chk("post_reset_first_grant_vld", 32'(grant_vld), 32'd1);
        chk("post_reset_first_grant", 32'(grant_id), 32'd0);
        wait_done(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/leaf_port_arbiter.md
Name: leaf_port_arbiter

Overview:
- Round-robin arbiter that shares one leaf_interface user input port among NUM_REQ user output streams.
- Sits between several operator output streams (vld/ack, 32-bit payload) and a single din_leaf_user2interface/vld/ack slot of the leaf wrapper.
- Grants in bursts of up to BURST_LEN words, so consecutive words from one producer stay contiguous on the BFT link.
- Output is registered.

Parameters:
- NUM_REQ, 2: number of requesting streams (2..8).
- PAYLOAD_BITS, 32: word width.
- BURST_LEN, 16: maximum words per grant (2..256).
- REQ_BITS, 3: width of grant_id (≥ clog2(NUM_REQ)).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  when low, no new grant issued; an in-flight burst completes
- din_user2arb  in  NUM_REQ*PAYLOAD_BITS  request payloads; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user2arb  in  NUM_REQ  per-requester valid
- ack_arb2user  out  NUM_REQ  per-requester accept
- dout_arb2interface  out  PAYLOAD_BITS  to leaf_interface din_leaf_user2interface slot
- vld_arb2interface  out  1  output valid
- ack_interface2arb  in  1  leaf_interface accept
- grant_vld  out  1  high while in BURST state
- grant_id  out  REQ_BITS  current or last granted requester

Behaviour:
- Handshake: a word transfers on any edge where vld and ack are both high.
  - Producers hold data and vld stable until acked.
  - The arbiter never drops or duplicates a word.
- Output register (one entry, o_vld/o_data):
  - can_load = !o_vld || ack_interface2arb.
  - vld_arb2interface = o_vld; dout_arb2interface = o_data.
  - On a user accept, load o_data and set o_vld.
  - Else, if ack_interface2arb is high, clear o_vld.
- ack_arb2user[i] = (state==BURST) && (grant==i) && can_load. This is combinational from ack_interface2arb. All other ack bits are 0.
- FSM states: IDLE, BURST.
  - IDLE: if enable && |vld_user2arb, select the first requester with vld high, scanning from last_grant+1 modulo NUM_REQ.
    - Register grant, set cnt=0, go BURST.
    - This costs one arbitration bubble cycle; no word is accepted in IDLE.
  - BURST, on an accepted word: cnt++.
    - If cnt reaches BURST_LEN-1, the accepting word is the last one: set last_grant=grant and go IDLE.
  - BURST, when the granted vld is low on an edge: release, set last_grant=grant, go IDLE. An idle producer cannot hold the port.
  - BURST, when the granted vld is high but can_load is low (backpressure): hold state and cnt, with no timeout.
- enable deasserted mid-burst: the burst continues until one of the release conditions above; no new grant follows.
- Single requester: it is re-granted after each burst.
  - Steady-state throughput is BURST_LEN words per BURST_LEN+1 cycles.
- All requesters active: grant order is 0,1,…,NUM_REQ-1,0,…, each receiving exactly BURST_LEN words per turn.
- cnt width is clog2(BURST_LEN). It never wraps, because release happens at BURST_LEN-1.
- grant_vld = (state==BURST). grant_id = grant register, which is retained in IDLE.
- Reset, at the next edge with reset high, regardless of state:
  - state=IDLE, cnt=0, o_vld=0, o_data=0, grant=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
  - All ack_arb2user=0, vld_arb2interface=0, grant_vld=0, grant_id=0.
  - A word held in the output register is discarded.
- Latency: first word appears on vld_arb2interface 2 cycles after vld_user2arb rises in IDLE (1 cycle arbitration, 1 cycle register).

Test Plan:
- Reset, then requester 0 sends 20 words 0x100..0x113 with ack_interface2arb=1 → output carries 0x100..0x10F, then a 1-cycle bubble, then 0x110..0x113 in order. grant_id=0 throughout.
- Both requesters continuously valid (req0 words 0xA000+n, req1 words 0xB000+n) → output carries 16 words of 0xA0xx, then 16 of 0xB0xx, alternating. No word is lost or repeated.
- Toggle ack_interface2arb randomly at 50% while req1 sends 40 words → all 40 words arrive in order. vld_arb2interface and dout_arb2interface stay stable whenever ack is low.
- Requester 1 deasserts vld after 3 words while req0 is waiting → burst releases after word 3, and the next grant goes to req0 (grant_id=0).
- enable=0 with both requesters valid → no ack_arb2user and grant_vld=0. Raising enable gives the first grant to the requester after last_grant.
- Assert reset for 1 cycle mid-burst with o_vld=1 → next cycle vld_arb2interface=0, grant_vld=0, ack_arb2user=0. The first post-reset grant goes to requester 0.
